// File: rtl/key_pkg.sv
// Shared types and constants for the key_ctrl debounce controller.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_ON  = 2'd1,
    HELD    = 2'd2,
    DEB_OFF = 2'd3
  } chan_state_e;

  localparam logic [1:0] EVT_PRESS = 2'b00;
  localparam logic [1:0] EVT_REL   = 2'b01;
  localparam logic [1:0] EVT_LONG  = 2'b10;

  // Clamp a derived width to at least one bit.
  function automatic int unsigned max1(input int unsigned v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One debounce channel: 2-flop sync, debounce FSM and sticky pending flags.
// Optional long-press hold counter enabled by KEY_LONGPRESS_EN.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned STABLE = 4,
  parameter int unsigned LONG   = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       key_i,
  input  logic [2:0] clr_i,
  output logic       level_o,
  output logic [2:0] pend_o
);

  localparam int unsigned SCNT_W = max1($clog2(STABLE + 1));

  logic [1:0]        sync_q;
  logic              sample_c;
  chan_state_e       state_q;
  logic [SCNT_W-1:0] scnt_q;
  logic [SCNT_W-1:0] scnt_inc_c;
  logic              level_q;
  logic              done_c;
  logic              acc_on_c;
  logic              acc_off_c;
  logic              long_c;
  logic [2:0]        set_c;
  logic [2:0]        pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], key_i};
  end

  assign sample_c   = sync_q[1];
  assign scnt_inc_c = scnt_q + SCNT_W'(1);
  // scnt is 0 in IDLE/HELD, so STABLE=1 accepts straight from those states.
  assign done_c     = (scnt_inc_c >= SCNT_W'(STABLE));
  assign acc_on_c   = tick_i && sample_c && done_c &&
                      ((state_q == IDLE) || (state_q == DEB_ON));
  assign acc_off_c  = tick_i && !sample_c && done_c &&
                      ((state_q == HELD) || (state_q == DEB_OFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      level_q <= 1'b0;
    end else if (tick_i) begin
      unique case (state_q)
        IDLE, DEB_ON: begin
          if (!sample_c) begin
            state_q <= IDLE;
            scnt_q  <= '0;
          end else if (acc_on_c) begin
            state_q <= HELD;
            scnt_q  <= '0;
            level_q <= 1'b1;
          end else begin
            state_q <= DEB_ON;
            scnt_q  <= scnt_inc_c;
          end
        end
        HELD, DEB_OFF: begin
          if (sample_c) begin
            state_q <= HELD;
            scnt_q  <= '0;
          end else if (acc_off_c) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            level_q <= 1'b0;
          end else begin
            state_q <= DEB_OFF;
            scnt_q  <= scnt_inc_c;
          end
        end
      endcase
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam int unsigned HOLD_W = max1($clog2(LONG + 1));

  logic [HOLD_W-1:0] hold_q;
  logic              holding_c;

  assign holding_c = (state_q == HELD) || (state_q == DEB_OFF);
  // Fires only on the LONG-1 -> LONG step, so once per hold.
  assign long_c    = tick_i && holding_c && (hold_q == HOLD_W'(LONG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_q <= '0;
    else if (acc_on_c)
      hold_q <= '0;
    else if (tick_i && holding_c && (hold_q != HOLD_W'(LONG)))
      hold_q <= hold_q + HOLD_W'(1);
  end
`else
  assign long_c = 1'b0;
`endif

  assign set_c = {long_c, acc_off_c, acc_on_c};

  // Sticky flags; a same-cycle set beats the arbiter's clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= set_c | (pend_q & ~clr_i);
  end

  assign level_o = level_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/key_ctrl.sv
// Multi-key debounce controller: shared tick prescaler, per-key channels and
// a round-robin arbiter feeding one valid/ready event port.
module key_ctrl
  import key_pkg::*;
#(
  parameter  int unsigned N        = 4,
  parameter  int unsigned TICK_DIV = 250000,
  parameter  int unsigned STABLE   = 4,
  parameter  int unsigned LONG     = 400,
  localparam int unsigned ID_W     = max1($clog2(N))
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    key_in,
  output logic [N-1:0]    key_level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [1:0]      evt_type
);

  localparam int unsigned DIV_W = max1($clog2(TICK_DIV));

  logic [DIV_W-1:0]    div_q;
  logic                tick_c;
  logic [N-1:0][2:0]   pend_c;
  logic [N-1:0][2:0]   clr_c;
  logic                gnt_c;
  logic [ID_W-1:0]     gnt_id_c;
  logic [1:0]          gnt_type_c;
  logic [ID_W-1:0]     scan_id_c;
  logic                evt_valid_q;
  logic [ID_W-1:0]     evt_id_q;
  logic [1:0]          evt_type_q;
  logic [ID_W-1:0]     rr_q;

  assign tick_c = (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    key_chan #(
      .STABLE (STABLE),
      .LONG   (LONG)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick_c),
      .key_i   (key_in[g]),
      .clr_i   (clr_c[g]),
      .level_o (key_level[g]),
      .pend_o  (pend_c[g])
    );
  end

  // Search from rr_q upward with wrap; press > release > long within a channel.
  always_comb begin
    gnt_c      = 1'b0;
    gnt_id_c   = '0;
    gnt_type_c = EVT_PRESS;
    scan_id_c  = '0;
    clr_c      = '0;
    if (!evt_valid_q) begin
      for (int unsigned i = 0; i < N; i++) begin
        scan_id_c = ID_W'((32'(rr_q) + i) % N);
        if (!gnt_c && (pend_c[scan_id_c] != 3'b000)) begin
          gnt_c    = 1'b1;
          gnt_id_c = scan_id_c;
          if (pend_c[scan_id_c][0]) begin
            gnt_type_c           = EVT_PRESS;
            clr_c[scan_id_c][0]  = 1'b1;
          end else if (pend_c[scan_id_c][1]) begin
            gnt_type_c           = EVT_REL;
            clr_c[scan_id_c][1]  = 1'b1;
          end else begin
            gnt_type_c           = EVT_LONG;
            clr_c[scan_id_c][2]  = 1'b1;
          end
        end
      end
    end
  end

  // Loads only while idle, so a handshake always leaves a one-cycle bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= EVT_PRESS;
      rr_q        <= '0;
    end else if (gnt_c) begin
      evt_valid_q <= 1'b1;
      evt_id_q    <= gnt_id_c;
      evt_type_q  <= gnt_type_c;
      rr_q        <= ID_W'((32'(gnt_id_c) + 1) % N);
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_type  = evt_type_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed self-checking bench for key_ctrl (N=4, TICK_DIV=4, STABLE=3, LONG=5).
`timescale 1ns/1ps
module tb_key_ctrl;

  localparam int unsigned N        = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned STABLE   = 3;
  localparam int unsigned LONG     = 5;
`ifdef KEY_LONGPRESS_EN
  localparam int LP = 1;
`else
  localparam int LP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;

  key_ctrl #(
    .N        (N),
    .TICK_DIV (TICK_DIV),
    .STABLE   (STABLE),
    .LONG     (LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_level (key_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  id;
    logic [1:0]  typ;
    logic [31:0] cyc;
  } ev_t;

  ev_t evq[$];

  // Log every accepted event, sampled between the drive point and the edge.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1)
      evq.push_back('{id: evt_id, typ: evt_type, cyc: cyc});
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic ev_t ev_at(input int k);
    ev_t e;
    e = '{id: 2'bxx, typ: 2'bxx, cyc: 'x};
    if (k >= 0 && k < evq.size()) e = evq[k];
    return e;
  endfunction

  function automatic int cnt_ev(input int from, input logic [1:0] id, input logic [1:0] typ);
    int n = 0;
    for (int k = from; k < evq.size(); k++)
      if (evq[k].id == id && evq[k].typ == typ) n++;
    return n;
  endfunction

  task automatic wait_lvl(input logic [1:0] idx, input logic val, input int maxc, output int lat);
    lat = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (key_level[idx] === val) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   base;
    int   bad;
    int   hi;
    ev_t  e;
    logic [1:0] exp_id [6];
    logic [1:0] exp_ty [6];

    rst = 1'b1; key_in = '0; evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(key_level), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id",    32'(evt_id), 0);
    chk("rst_type",  32'(evt_type), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean press on key 2, held 40 cycles.
    base = evq.size();
    key_in[2] = 1'b1;
    wait_lvl(2'd2, 1'b1, 20, lat);
    chk("t1_press_latency_ok", 32'(lat >= 11 && lat <= 15), 1);
    if (lat > 0 && lat < 40) repeat (40 - lat) @(negedge clk);
    chk("t1_press_events", 32'(cnt_ev(base, 2'd2, 2'b00)), 1);
    chk("t1_events_while_held", 32'(evq.size() - base), 32'(1 + LP));
    e = ev_at(base);
    chk("t1_first_id",   32'(e.id), 2);
    chk("t1_first_type", 32'(e.typ), 0);
    key_in[2] = 1'b0;
    wait_lvl(2'd2, 1'b0, 20, lat);
    chk("t1_release_seen", 32'(lat > 0), 1);
    repeat (4) @(negedge clk);
    chk("t1_release_events", 32'(cnt_ev(base, 2'd2, 2'b01)), 1);
    chk("t1_total_events", 32'(evq.size() - base), 32'(2 + LP));

    // Key 1 bouncing every 3 cycles never settles for 3 ticks.
    base = evq.size(); hi = 0;
    for (int c = 0; c < 30; c++) begin
      key_in[1] = ((c / 3) % 2 == 0);
      @(negedge clk);
      if (key_level[1] !== 1'b0) hi = 1;
    end
    key_in[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (key_level[1] !== 1'b0) hi = 1;
    end
    chk("t2_bounce_level", 32'(hi), 0);
    chk("t2_bounce_events", 32'(evq.size() - base), 0);

    // Fresh reset so the round-robin pointer starts at 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Keys 0, 1, 3 accepted on the same tick.
    base = evq.size();
    key_in = 4'b1011;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (key_level !== 4'b0000) begin
        lat = c;
        break;
      end
    end
    chk("t3_same_tick_level", 32'(key_level), 32'hB);
    key_in = 4'b0000;
    repeat (30) @(negedge clk);
    chk("t3_event_count", 32'(evq.size() - base), 6);
    exp_id = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    exp_ty = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int k = 0; k < 6; k++) begin
      e = ev_at(base + k);
      chk($sformatf("t3_ev%0d_id", k),   32'(e.id),  32'(exp_id[k]));
      chk($sformatf("t3_ev%0d_type", k), 32'(e.typ), 32'(exp_ty[k]));
    end
    chk("t3_bubble_01", ev_at(base + 1).cyc - ev_at(base).cyc, 2);
    chk("t3_bubble_12", ev_at(base + 2).cyc - ev_at(base + 1).cyc, 2);

    // Back-pressure: key 2 presses and releases while ready is low.
    base = evq.size();
    evt_ready = 1'b0;
    key_in[2] = 1'b1;
    wait_lvl(2'd2, 1'b1, 20, lat);
    chk("t4_press_seen", 32'(lat > 0), 1);
    @(negedge clk);
    chk("t4_valid_up", 32'(evt_valid), 1);
    key_in[2] = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!(evt_valid === 1'b1 && evt_id === 2'd2 && evt_type === 2'b00)) bad++;
    end
    chk("t4_held_stable", 32'(bad), 0);
    chk("t4_level_fell", 32'(key_level[2]), 0);
    chk("t4_no_accept", 32'(evq.size() - base), 0);
    evt_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_event_count", 32'(evq.size() - base), 2);
    e = ev_at(base);
    chk("t4_ev0", 32'({e.id, e.typ}), 32'({2'd2, 2'b00}));
    e = ev_at(base + 1);
    chk("t4_ev1", 32'({e.id, e.typ}), 32'({2'd2, 2'b01}));

    // Reset while key 0 is debouncing and a key 3 event is stalled.
    evt_ready = 1'b0;
    key_in[3] = 1'b1;
    wait_lvl(2'd3, 1'b1, 20, lat);
    @(negedge clk);
    chk("t5_pre_valid", 32'(evt_valid), 1);
    chk("t5_pre_id", 32'(evt_id), 3);
    key_in[0] = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_level", 32'(key_level), 0);
    chk("t5_rst_valid", 32'(evt_valid), 0);
    chk("t5_rst_id",    32'(evt_id), 0);
    chk("t5_rst_type",  32'(evt_type), 0);
    evt_ready = 1'b1;
    repeat (2) @(negedge clk);
    base = evq.size();
    rst = 1'b0;
    repeat (11) @(negedge clk);
    chk("t5_level_before_debounce", 32'(key_level), 0);
    @(negedge clk);
    chk("t5_level_after_debounce", 32'(key_level), 32'h9);
    key_in = 4'b0000;
    repeat (25) @(negedge clk);
    chk("t5_event_count", 32'(evq.size() - base), 4);
    e = ev_at(base);
    chk("t5_ev0", 32'({e.id, e.typ}), 32'({2'd0, 2'b00}));
    e = ev_at(base + 1);
    chk("t5_ev1", 32'({e.id, e.typ}), 32'({2'd3, 2'b00}));
    e = ev_at(base + 2);
    chk("t5_ev2", 32'({e.id, e.typ}), 32'({2'd0, 2'b01}));
    e = ev_at(base + 3);
    chk("t5_ev3", 32'({e.id, e.typ}), 32'({2'd3, 2'b01}));

    // Key 3 held for 40 cycles: long press only when the option is built in.
    base = evq.size();
    key_in[3] = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_level_held", 32'(key_level[3]), 1);
    key_in[3] = 1'b0;
    repeat (25) @(negedge clk);
    chk("t6_event_count", 32'(evq.size() - base), 32'(2 + LP));
    chk("t6_long_count", 32'(cnt_ev(base, 2'd3, 2'b10)), 32'(LP));
    e = ev_at(base);
    chk("t6_ev0", 32'({e.id, e.typ}), 32'({2'd3, 2'b00}));
    if (LP == 1) begin
      e = ev_at(base + 1);
      chk("t6_ev1_long", 32'({e.id, e.typ}), 32'({2'd3, 2'b10}));
    end
    e = ev_at(base + 1 + LP);
    chk("t6_ev_release", 32'({e.id, e.typ}), 32'({2'd3, 2'b01}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_ctrl.md
# key_ctrl

Multi-key debounce controller that shares one sample-tick prescaler among `N` push-button channels. Each channel runs its own debounce FSM. A round-robin arbiter serialises the resulting press and release events onto a single valid/ready event port. It sits between the raw board buttons and the front-panel logic, and replaces per-button free-running debounce counters with one scheduled resource.

## Interface
- `N`, 4: number of key channels (2..16).
- `TICK_DIV`, 250000: clock cycles per sample tick (2.5 ms at 100 MHz).
- `STABLE`, 4: consecutive equal tick samples required to accept a level change.
- `LONG`, 400: ticks a key must stay held to raise a long-press event. Used only with `KEY_LONGPRESS_EN`.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_in` in N: raw, asynchronous key levels; 1 = pressed.
- `key_level` out N: debounced level per key.
- `evt_valid` out 1: event word valid.
- `evt_ready` in 1: consumer accepts the event.
- `evt_id` out max(1,$clog2(N)): channel index of the event.
- `evt_type` out 2: event type. 00 = press, 01 = release, 10 = long press; 11 is never produced.

## Operation
- Input sync: each `key_in` bit passes through a 2-flop synchroniser. The channel samples only the synchronised value.
- Prescaler: counter 0..TICK_DIV-1. `tick` pulses for one cycle when the count is TICK_DIV-1, and the counter wraps to 0 in that cycle. All channels sample on the same tick.
- Channel FSM. States are IDLE, DEB_ON, HELD, DEB_OFF. The stable counter is `scnt`. Transitions happen only on a tick.
  - IDLE: sample=1 → DEB_ON, scnt=1.
  - DEB_ON: sample=1 → scnt+1. When scnt+1 reaches STABLE: → HELD, `key_level`=1, set pend_press. Sample=0 → IDLE, scnt=0.
  - HELD: sample=0 → DEB_OFF, scnt=1.
  - DEB_OFF: mirror of DEB_ON. On completion: → IDLE, `key_level`=0, set pend_rel. Sample=1 → HELD.
  - STABLE=1: the level changes on the first differing tick, with no intermediate state lingering.
- Pending flags: each channel holds one sticky flag per event type. Repeated events of the same type before service coalesce into one flag (no counting). If a set and a clear of the same flag occur in the same cycle, the set wins.
- Arbiter:
  - When `evt_valid`=0 and any flag is pending, it grants the first channel with a pending flag, searching from `rr_ptr` upward with wrap.
  - Within the granted channel, type priority is press > release > long.
  - The grant loads `evt_id`/`evt_type`, clears that flag, and sets `evt_valid` on the next edge.
  - `rr_ptr` is set to grant+1 mod N at load time.
- Handshake:
  - `evt_valid`, `evt_id` and `evt_type` hold stable while `evt_valid`=1 and `evt_ready`=0.
  - On `evt_valid`&&`evt_ready`, `evt_valid` drops on the next edge. No new load happens in that same cycle, so there is a one-cycle bubble between events.
- Reset (asynchronous):
  - Outputs: `key_level`=0, `evt_valid`=0, `evt_id`=0, `evt_type`=00.
  - Internal state: sync flops, prescaler, `rr_ptr`, all flags and all FSMs (IDLE, scnt=0) are cleared.
  - Reset mid-debounce or mid-handshake discards all pending events.

## Timing
- Press latency: `key_level` rises between 2+(STABLE-1)·TICK_DIV+1 and 2+STABLE·TICK_DIV+1 cycles after a clean input edge, depending on prescaler phase.
- Event latency: `evt_valid` rises 1 cycle after the flag is set, if the port is idle.
- Throughput: at most one event every 2 cycles.
- Counter widths: prescaler $clog2(TICK_DIV); scnt $clog2(STABLE+1); long counter $clog2(LONG+1). All counters saturate or clear and never wrap.

## Configuration
- `KEY_LONGPRESS_EN` defined:
  - Each channel has a hold counter that clears on entry to HELD and increments each tick while in HELD or DEB_OFF.
  - When the counter reaches LONG, pend_long is set once per hold.
  - The counter saturates; no repeat events.
- `KEY_LONGPRESS_EN` undefined: no hold counter or pend_long; type 10 is never produced.

## Structure
- Package `key_pkg`:
  - channel state enum (IDLE, DEB_ON, HELD, DEB_OFF);
  - `evt_type` localparams EVT_PRESS, EVT_REL, EVT_LONG.
- Sub-module `key_chan`: one instance per channel via generate. It contains the synchroniser, FSM, scnt, optional hold counter and pending flags, and has inputs `tick` and `clr[2:0]`.
- Top level `key_ctrl` holds the prescaler, round-robin arbiter and event register.

## Test plan
Bench parameters: N=4, TICK_DIV=4, STABLE=3, LONG=5.
- Clean press on key 2, held for 40 cycles, `evt_ready`=1 → `key_level[2]` rises within 15 cycles; exactly one event {id=2, type=00}.
- Key 1 input bouncing 1/0 every 3 cycles for 30 cycles, then 0 → `key_level[1]` stays 0 and no event.
- Keys 0, 1 and 3 all become stable pressed in the same tick, `evt_ready` held 1 → events come out in id order 0, 1, 3 with one bubble between them; next grant starts search at 0.
- `evt_ready`=0 for 20 cycles while key 2 presses and releases → `evt_valid` holds {2, 00} unchanged; after ready, {2, 01} follows.
- Reset asserted while key 0 is in DEB_ON with press pending → all outputs 0 immediately; after release of `rst` with the input still 1, a fresh full debounce is needed before the event.
- With `KEY_LONGPRESS_EN`, key 3 held for 40 cycles → events {3, 00} then {3, 10} exactly once; release gives {3, 01}.
